// File: rtl/multiplicador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_pkg
// Description : Shared types, constants and helpers for the sequential
//               signed shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplicador_pkg;

    localparam int TAMANYO_DEF = 32;

    // Widest operand abs_val can handle; operands are zero-extended to this.
    localparam int TAMANYO_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPERA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    // Magnitude of a tamanyo-bit two's-complement value held in the low bits
    // of x. The result is unsigned, so -2^(tamanyo-1) maps to 2^(tamanyo-1).
    function automatic logic [TAMANYO_MAX-1:0] abs_val(
        input logic [TAMANYO_MAX-1:0] x,
        input int unsigned            tamanyo
    );
        logic [TAMANYO_MAX-1:0] mask;
        mask = {TAMANYO_MAX{1'b1}} >> (TAMANYO_MAX - tamanyo);
        if (x[tamanyo-1])
            abs_val = (~x + 1'b1) & mask;
        else
            abs_val = x & mask;
    endfunction

endpackage : multiplicador_pkg
`default_nettype wire

// File: rtl/multiplicador_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_datapath
// Description : Accumulator, shifted multiplicand, multiplier shift register
//               and final sign correction, driven by FSM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_datapath
    import multiplicador_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   carga,
    input  logic                   itera,
    input  logic                   fin,
    input  logic [tamanyo-1:0]     multiplicando,
    input  logic [tamanyo-1:0]     multiplicador,
    output logic [2*tamanyo-1:0]   producto
);

    localparam int c_ANCHO = 2 * tamanyo;

    logic [c_ANCHO-1:0]     r_acc;
    logic [c_ANCHO-1:0]     r_mcand;
    logic [tamanyo-1:0]     r_mult;
    logic                   r_signo;
    logic [c_ANCHO-1:0]     r_producto;

    logic [TAMANYO_MAX-1:0] w_ext_a;
    logic [TAMANYO_MAX-1:0] w_ext_b;
    logic [tamanyo-1:0]     w_abs_a;
    logic [tamanyo-1:0]     w_abs_b;
    logic                   w_signo;
    logic [c_ANCHO-1:0]     w_suma;

    assign w_ext_a = TAMANYO_MAX'(multiplicando);
    assign w_ext_b = TAMANYO_MAX'(multiplicador);
    assign w_abs_a = tamanyo'(abs_val(w_ext_a, tamanyo));
    assign w_abs_b = tamanyo'(abs_val(w_ext_b, tamanyo));
    assign w_signo = multiplicando[tamanyo-1] ^ multiplicador[tamanyo-1];

    // Magnitude product is at most 2^(2*tamanyo-2), so this sum cannot wrap.
    assign w_suma  = r_acc + r_mcand;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mult     <= '0;
            r_signo    <= 1'b0;
            r_producto <= '0;
        end else begin
            if (carga) begin
                r_acc   <= '0;
                r_mcand <= c_ANCHO'(w_abs_a);
                r_mult  <= w_abs_b;
                r_signo <= w_signo;
            end else if (itera) begin
                if (r_mult[0])
                    r_acc <= w_suma;
                r_mcand <= r_mcand << 1;
                r_mult  <= r_mult >> 1;
            end
            // Negating a zero accumulator yields zero, never a negative zero.
            if (fin)
                r_producto <= r_signo ? (~r_acc + 1'b1) : r_acc;
        end
    end

    assign producto = r_producto;

endmodule : multiplicador_datapath
`default_nettype wire

// File: rtl/multiplicador_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_seq
// Description : Sequential signed multiplier, one multiplier bit per clock,
//               START/DONE handshake, latency tamanyo+1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_seq
    import multiplicador_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [tamanyo-1:0]     MULTIPLICANDO,
    input  logic [tamanyo-1:0]     MULTIPLICADOR,
    output logic [2*tamanyo-1:0]   PRODUCTO,
    output logic                   DONE
);

    localparam int          c_CW     = $clog2(tamanyo);
    localparam [c_CW-1:0]   c_ULTIMA = c_CW'(tamanyo - 1);

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [c_CW-1:0]  r_cuenta;
    logic             r_done;
    logic             w_carga;
    logic             w_itera;
    logic             w_fin;

    always_ff @(posedge CLK) begin
        if (RST)
            r_estado <= IDLE;
        else
            r_estado <= w_estado_sig;
    end

    // START is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        w_estado_sig = r_estado;
        w_carga      = 1'b0;
        w_itera      = 1'b0;
        w_fin        = 1'b0;
        case (r_estado)
            IDLE: begin
                if (START) begin
                    w_carga      = 1'b1;
                    w_estado_sig = OPERA;
                end
            end
            OPERA: begin
                w_itera = 1'b1;
                if (r_cuenta == c_ULTIMA)
                    w_estado_sig = FIN;
            end
            FIN: begin
                w_fin        = 1'b1;
                w_estado_sig = IDLE;
            end
            default: w_estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cuenta <= '0;
            r_done   <= 1'b0;
        end else begin
            if (w_carga)
                r_cuenta <= '0;
            else if (w_itera)
                r_cuenta <= r_cuenta + 1'b1;
            r_done <= w_fin;
        end
    end

    multiplicador_datapath #(
        .tamanyo       (tamanyo)
    ) u_datapath (
        .clk           (CLK),
        .rst           (RST),
        .carga         (w_carga),
        .itera         (w_itera),
        .fin           (w_fin),
        .multiplicando (MULTIPLICANDO),
        .multiplicador (MULTIPLICADOR),
        .producto      (PRODUCTO)
    );

    assign DONE = r_done;

endmodule : multiplicador_seq
`default_nettype wire

// File: doc/multiplicador_seq.md
# multiplicador_seq

Sequential signed shift-and-add multiplier, the inverse datapath of the team's sequential divisor. It uses the same START/DONE handshake, so a bench or a top level can chain the two for round-trip checking: product = quotient × denominator, then + remainder. It takes two `tamanyo`-bit two's-complement operands and produces a `2*tamanyo`-bit signed product with fixed latency. It uses one adder, processes one multiplier bit per clock, and has no pipelining.

## Interface
- `tamanyo`, default 32: operand width in bits; must be ≥ 2.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset. **Synchronous, active-high.**
- `START` in 1: request; sampled only in state IDLE.
- `MULTIPLICANDO` in `tamanyo`: signed operand A; sampled on the accepting edge only.
- `MULTIPLICADOR` in `tamanyo`: signed operand B; sampled on the accepting edge only.
- `PRODUCTO` out `2*tamanyo`: signed result A×B; holds until the next result is written.
- `DONE` out 1: one-cycle pulse marking PRODUCTO as newly valid.

## Operation
- **Reset values:** PRODUCTO = 0, DONE = 0, state = IDLE, all internal registers 0.
- **FSM states:** IDLE → OPERA → FIN → IDLE.
- **IDLE:**
  - START=1 accepts a request.
  - On the accepting edge, latch |A| and |B| as unsigned `tamanyo`-bit values.
  - Latch `signo = A[msb] ^ B[msb]`.
  - Clear the accumulator (`2*tamanyo` bits) and the iteration counter, then go to OPERA.
  - START=0 keeps the block in IDLE.
- **OPERA:** one iteration per edge, exactly `tamanyo` iterations.
  - If the multiplier LSB is 1: `acc += mcand_shift`.
  - Then `mcand_shift <<= 1` (`2*tamanyo` bits) and `mult >>= 1`.
  - The counter runs 0..`tamanyo`-1; on the last iteration go to FIN.
  - No early exit on zero operands.
- **FIN:** write PRODUCTO = `signo ? -acc : acc` (`2*tamanyo`-bit two's complement), set DONE=1, go to IDLE.
- **Width rules:**
  - |−2^(tamanyo−1)| = 2^(tamanyo−1) fits unsigned `tamanyo` bits, so the absolute value is taken without overflow.
  - The magnitude of the product is at most 2^(2·tamanyo−2), so the accumulator never overflows.
  - Negating 0 gives 0, so a zero product is never negative.
- **Busy behaviour:** START in OPERA or FIN is ignored and not queued. Operand changes while busy have no effect.

## Timing
- Accepting edge k (IDLE, START=1).
- Iterations on edges k+1 … k+`tamanyo`.
- FIN edge is k+`tamanyo`+1. DONE=1 and the new PRODUCTO are visible from that edge for exactly one cycle, then DONE returns to 0.
- **Latency:** `tamanyo`+1 clocks from the accepting edge to DONE (33 for the default).
- **Throughput:** one result per `tamanyo`+2 cycles.
- **Back-to-back:** the block is in IDLE during the DONE cycle, so START=1 there is accepted on the next edge. The next DONE follows `tamanyo`+1 edges later.
- **Reset mid-operation:** RST=1 on any edge forces the reset values on that edge.
  - The in-flight result is discarded and no DONE is produced.
  - RST has priority over START on the same edge.
- PRODUCTO changes only on FIN edges and reset edges.

## Structure
- Shared package `multiplicador_pkg`:
  - `estado_t` enum {IDLE, OPERA, FIN}.
  - Helper function `abs_val`, parameterised through `tamanyo`.
  - Default-width constant `TAMANYO_DEF = 32`.
- One natural sub-module, `multiplicador_datapath`:
  - Holds the accumulator, shifted multiplicand, multiplier shift register and final negation.
  - Controlled by `carga`, `itera` and `fin` strobes from the FSM in `multiplicador_seq`.
- A `multiplicador_top` wrapper exposes the ports on the team's existing bus interface (stimulus/duv/monitor modports). It uses the same scoreboard pattern as the divisor bench.

## Test plan
All scenarios use `tamanyo`=32.
- **Basic:** reset, then A=7, B=6, START for one cycle → DONE pulses once, 33 clocks after the accepting edge; PRODUCTO=0x0000_0000_0000_002A; DONE low before and after.
- **Signs:**
  - A=−3, B=5 → PRODUCTO=0xFFFF_FFFF_FFFF_FFF1.
  - A=−4, B=−4 → 0x0000_0000_0000_0010.
  - A=0, B=−9 → 0.
- **Extremes:**
  - A=B=0x8000_0000 → 0x4000_0000_0000_0000.
  - A=0x7FFF_FFFF, B=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0001.
- **Busy START:** pulse START with new operands 10 cycles into an operation → the first result is unchanged, only one DONE is produced, the second request is lost.
- **Reset mid-op:** RST=1 at iteration 15 → PRODUCTO=0 and DONE=0 on the next edge, and no DONE follows. A subsequent 2×3 gives 6 with normal latency.
- **Back-to-back and random:**
  - START held high through a DONE cycle → the second operation is accepted in the DONE cycle; DONEs are 34 cycles apart.
  - 1000 random operand pairs checked against a scoreboard reference A×B.
  - Round trip through the divisor: COC×DENOMINADOR + RES == NUMERADOR.
